// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM state types, oversampling constants and baud divisor helper.
// Parity states exist only when UART_PARITY_EN is defined.
package uart_pkg;
    localparam int OVERSAMPLE = 16;
    localparam int MID_SAMPLE = 8;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
`ifdef UART_PARITY_EN
        RX_PARITY,
`endif
        RX_STOP
    } rx_state_t;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
`ifdef UART_PARITY_EN
        TX_PARITY,
`endif
        TX_STOP
    } tx_state_t;

    function automatic int baud_divisor(input int clock_rate, input int baud_rate);
        int d;
        d = clock_rate / (baud_rate * OVERSAMPLE);
        return (d < 1) ? 1 : d;
    endfunction
endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: first-word fall-through FIFO with extra-MSB pointers.
// When empty, data_o keeps showing the last word popped.
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             empty_o,
    output logic             full_o
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0] wptr_q, rptr_q;
    logic [WIDTH-1:0] last_q;
    logic do_push, do_pop;
    assign empty_o = wptr_q == rptr_q;
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign data_o  = empty_o ? last_q : mem_q[rptr_q[AW-1:0]];
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= data_i;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
            last_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop) begin
                rptr_q <= rptr_q + 1'b1;
                last_q <= mem_q[rptr_q[AW-1:0]];
            end
        end
    end
endmodule

// File: rtl/uart_fifo_ctrl.sv
// uart_fifo_ctrl: buffered UART with 16x oversampling RX, sticky error flags and RX/TX FIFOs.
// Define UART_PARITY_EN to add a parity bit per frame (PARITY_ODD selects odd parity).
module uart_fifo_ctrl
    import uart_pkg::*;
#(
    parameter int CLOCK_RATE = 100_000_000,
    parameter int BAUD_RATE  = 460_800,
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int STOP_BITS  = 1
`ifdef UART_PARITY_EN
    ,
    parameter bit PARITY_ODD = 1'b0
`endif
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 rx,
    output logic                 tx,
    input  logic [DATA_BITS-1:0] write_tx_data,
    input  logic                 enable_tx_write,
    input  logic                 enable_rx_read,
    output logic [DATA_BITS-1:0] read_rx_data,
    output logic                 rx_empty,
    output logic                 tx_full,
    input  logic                 clear_errors,
    output logic                 frame_error,
    output logic                 overrun_error,
    output logic                 parity_error
);
    localparam int DIV = baud_divisor(CLOCK_RATE, BAUD_RATE);
    localparam int CW  = $clog2(DIV + 1);
    localparam logic [3:0] LAST_TICK = 4'(OVERSAMPLE - 1);
    localparam logic [3:0] MID_TICK  = 4'(MID_SAMPLE - 1);
    localparam logic [3:0] DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0] STOP_LAST = 4'(STOP_BITS - 1);
`ifdef UART_PARITY_EN
    localparam rx_state_t RX_AFTER_DATA = RX_PARITY;
    localparam tx_state_t TX_AFTER_DATA = TX_PARITY;
`else
    localparam rx_state_t RX_AFTER_DATA = RX_STOP;
    localparam tx_state_t TX_AFTER_DATA = TX_STOP;
`endif

    logic [CW-1:0] baud_q;
    logic tick;
    logic [2:0] rx_sync_q;
    logic rx_s;
    rx_state_t rx_state_q, rx_state_d;
    tx_state_t tx_state_q, tx_state_d;
    logic [3:0] rx_cnt_q, rx_cnt_d, rx_bit_q, rx_bit_d;
    logic [3:0] tx_cnt_q, tx_cnt_d, tx_bit_q, tx_bit_d;
    logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d, tx_shift_q, tx_shift_d, tx_head;
    logic tx_q, tx_d;
    logic rx_push, rx_full, tx_pop, tx_empty, rx_bad;
    logic set_ferr, set_oerr, frame_error_q, overrun_error_q;
`ifdef UART_PARITY_EN
    logic rx_bad_q, rx_bad_d, set_perr, parity_error_q, tx_par_q, tx_par_d;
    assign rx_bad = rx_bad_q;
    assign parity_error = parity_error_q;
`else
    assign rx_bad = 1'b0;
    assign parity_error = 1'b0;
`endif

    assign tick = baud_q == CW'(DIV - 1);
    // rx_sync_q[1:0] is the synchronizer; [2] holds the previous synchronized sample
    assign rx_s = rx_sync_q[1];
    assign tx = tx_q;
    assign frame_error = frame_error_q;
    assign overrun_error = overrun_error_q;

    uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(clk), .reset(reset), .push_i(rx_push), .data_i(rx_shift_q), .pop_i(enable_rx_read),
        .data_o(read_rx_data), .empty_o(rx_empty), .full_o(rx_full)
    );

    uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(clk), .reset(reset), .push_i(enable_tx_write), .data_i(write_tx_data), .pop_i(tx_pop),
        .data_o(tx_head), .empty_o(tx_empty), .full_o(tx_full)
    );

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_push    = 1'b0;
        set_ferr   = 1'b0;
        set_oerr   = 1'b0;
`ifdef UART_PARITY_EN
        rx_bad_d   = rx_bad_q;
        set_perr   = 1'b0;
`endif
        case (rx_state_q)
            RX_IDLE: if (enable && rx_sync_q[2] && !rx_s) begin
                rx_state_d = RX_START;
                rx_cnt_d   = '0;
            end
            RX_START: if (tick) begin
                rx_cnt_d = rx_cnt_q + 1'b1;
                if (rx_cnt_q == MID_TICK) begin
                    rx_state_d = rx_s ? RX_IDLE : RX_DATA;
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
`ifdef UART_PARITY_EN
                    rx_bad_d   = 1'b0;
`endif
                end
            end
            RX_DATA: if (tick) begin
                rx_cnt_d = rx_cnt_q + 1'b1;
                if (rx_cnt_q == LAST_TICK) begin
                    rx_shift_d = {rx_s, rx_shift_q[DATA_BITS-1:1]};
                    rx_bit_d   = rx_bit_q + 1'b1;
                    if (rx_bit_q == DATA_LAST) rx_state_d = RX_AFTER_DATA;
                end
            end
`ifdef UART_PARITY_EN
            RX_PARITY: if (tick) begin
                rx_cnt_d = rx_cnt_q + 1'b1;
                if (rx_cnt_q == LAST_TICK) begin
                    rx_state_d = RX_STOP;
                    rx_bad_d   = ((^rx_shift_q) ^ rx_s) != PARITY_ODD;
                    set_perr   = rx_bad_d;
                end
            end
`endif
            RX_STOP: if (tick) begin
                rx_cnt_d = rx_cnt_q + 1'b1;
                if (rx_cnt_q == LAST_TICK) begin
                    rx_state_d = RX_IDLE;
                    set_ferr   = !rx_s;
                    set_oerr   = rx_s && !rx_bad && rx_full;
                    rx_push    = rx_s && !rx_bad && !rx_full;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_pop     = 1'b0;
`ifdef UART_PARITY_EN
        tx_par_d   = tx_par_q;
`endif
        case (tx_state_q)
            TX_IDLE: if (tick && enable && !tx_empty) begin
                tx_pop     = 1'b1;
                tx_shift_d = tx_head;
                tx_cnt_d   = '0;
                tx_state_d = TX_START;
`ifdef UART_PARITY_EN
                tx_par_d   = (^tx_head) ^ PARITY_ODD;
`endif
            end
            TX_START: if (tick) begin
                tx_cnt_d = tx_cnt_q + 1'b1;
                if (tx_cnt_q == LAST_TICK) begin
                    tx_state_d = TX_DATA;
                    tx_bit_d   = '0;
                end
            end
            TX_DATA: if (tick) begin
                tx_cnt_d = tx_cnt_q + 1'b1;
                if (tx_cnt_q == LAST_TICK) begin
                    tx_shift_d = tx_shift_q >> 1;
                    tx_bit_d   = tx_bit_q + 1'b1;
                    if (tx_bit_q == DATA_LAST) begin
                        tx_state_d = TX_AFTER_DATA;
                        tx_bit_d   = '0;
                    end
                end
            end
`ifdef UART_PARITY_EN
            TX_PARITY: if (tick) begin
                tx_cnt_d = tx_cnt_q + 1'b1;
                if (tx_cnt_q == LAST_TICK) tx_state_d = TX_STOP;
            end
`endif
            TX_STOP: if (tick) begin
                tx_cnt_d = tx_cnt_q + 1'b1;
                if (tx_cnt_q == LAST_TICK) begin
                    tx_bit_d = tx_bit_q + 1'b1;
                    if (tx_bit_q == STOP_LAST) tx_state_d = TX_IDLE;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
        // tx is registered from the next state so the pin never glitches on state decode
        tx_d = 1'b1;
        if (tx_state_d == TX_START) tx_d = 1'b0;
        if (tx_state_d == TX_DATA) tx_d = tx_shift_d[0];
`ifdef UART_PARITY_EN
        if (tx_state_d == TX_PARITY) tx_d = tx_par_d;
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            baud_q          <= '0;
            rx_sync_q       <= '1;
            rx_state_q      <= RX_IDLE;
            rx_cnt_q        <= '0;
            rx_bit_q        <= '0;
            rx_shift_q      <= '0;
            tx_state_q      <= TX_IDLE;
            tx_cnt_q        <= '0;
            tx_bit_q        <= '0;
            tx_shift_q      <= '0;
            tx_q            <= 1'b1;
            frame_error_q   <= 1'b0;
            overrun_error_q <= 1'b0;
`ifdef UART_PARITY_EN
            rx_bad_q        <= 1'b0;
            tx_par_q        <= 1'b0;
            parity_error_q  <= 1'b0;
`endif
        end else begin
            baud_q          <= tick ? '0 : baud_q + 1'b1;
            rx_sync_q       <= {rx_sync_q[1:0], rx};
            rx_state_q      <= rx_state_d;
            rx_cnt_q        <= rx_cnt_d;
            rx_bit_q        <= rx_bit_d;
            rx_shift_q      <= rx_shift_d;
            tx_state_q      <= tx_state_d;
            tx_cnt_q        <= tx_cnt_d;
            tx_bit_q        <= tx_bit_d;
            tx_shift_q      <= tx_shift_d;
            tx_q            <= tx_d;
            frame_error_q   <= set_ferr | (frame_error_q & ~clear_errors);
            overrun_error_q <= set_oerr | (overrun_error_q & ~clear_errors);
`ifdef UART_PARITY_EN
            rx_bad_q        <= rx_bad_d;
            tx_par_q        <= tx_par_d;
            parity_error_q  <= set_perr | (parity_error_q & ~clear_errors);
`endif
        end
    end
endmodule

// File: tb/tb_uart_fifo_ctrl.sv
// tb_uart_fifo_ctrl: directed vector table for RX frames plus sequences for TX, loopback, overrun and reset.
module tb_uart_fifo_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic enable = 1'b0;
    logic rx_drv = 1'b1;
    logic loop = 1'b0;
    logic rx, tx;
    logic [7:0] write_tx_data = '0;
    logic enable_tx_write = 1'b0;
    logic enable_rx_read = 1'b0;
    logic clear_errors = 1'b0;
    logic [7:0] read_rx_data;
    logic rx_empty, tx_full, frame_error, overrun_error, parity_error;
    int total = 0;
    int bad = 0;

    typedef struct {
        logic [7:0] d;
        logic stop;
        logic glitch;
        logic en;
        logic exp_empty;
        logic exp_ferr;
    } vec_t;
    vec_t vecs[8];

    always #5 clk = ~clk;
    assign rx = loop ? tx : rx_drv;

    uart_fifo_ctrl #(
        .CLOCK_RATE(16_000_000), .BAUD_RATE(1_000_000), .DATA_BITS(8), .FIFO_DEPTH(16), .STOP_BITS(1)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .rx(rx), .tx(tx),
        .write_tx_data(write_tx_data), .enable_tx_write(enable_tx_write), .enable_rx_read(enable_rx_read),
        .read_rx_data(read_rx_data), .rx_empty(rx_empty), .tx_full(tx_full), .clear_errors(clear_errors),
        .frame_error(frame_error), .overrun_error(overrun_error), .parity_error(parity_error)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input logic flip);
        rx_drv = 1'b0;
        repeat (16) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_drv = d[i];
            repeat (16) @(negedge clk);
        end
`ifdef UART_PARITY_EN
        rx_drv = (^d) ^ flip;
        repeat (16) @(negedge clk);
`endif
        rx_drv = stop;
        repeat (16) @(negedge clk);
        rx_drv = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic push(input logic [7:0] d);
        @(negedge clk);
        write_tx_data = d;
        enable_tx_write = 1'b1;
        @(negedge clk);
        enable_tx_write = 1'b0;
    endtask

    task automatic pop();
        @(negedge clk);
        enable_rx_read = 1'b1;
        @(negedge clk);
        enable_rx_read = 1'b0;
    endtask

    task automatic clear();
        @(negedge clk);
        clear_errors = 1'b1;
        @(negedge clk);
        clear_errors = 1'b0;
    endtask

    task automatic wait_tx_start(input string name, output logic ok);
        int w;
        w = 0;
        while (tx !== 1'b0 && w < 100) begin
            @(negedge clk);
            w++;
        end
        ok = w < 100;
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s start: tx stayed high for %0d cycles, required to go low", name, w);
        end
    endtask

    task automatic check_tx(input logic [7:0] d, input string name);
        logic [11:0] bits;
        logic ok;
        int n;
        bits = '1;
        bits[0] = 1'b0;
        bits[8:1] = d;
`ifdef UART_PARITY_EN
        bits[9] = ^d;
        n = 11;
`else
        n = 10;
`endif
        wait_tx_start(name, ok);
        if (!ok) return;
        for (int i = 0; i < n * 16; i++) begin
            check($sformatf("%s bit%0d cyc%0d", name, i / 16, i % 16), {31'd0, tx}, {31'd0, bits[i / 16]});
            @(negedge clk);
        end
        repeat (20) @(negedge clk);
        check({name, " idle after"}, {31'd0, tx}, 32'd1);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic ok;
        vecs[0] = '{d: 8'h3C, stop: 1'b1, glitch: 1'b0, en: 1'b1, exp_empty: 1'b0, exp_ferr: 1'b0};
        vecs[1] = '{d: 8'h3C, stop: 1'b0, glitch: 1'b0, en: 1'b1, exp_empty: 1'b1, exp_ferr: 1'b1};
        vecs[2] = '{d: 8'h00, stop: 1'b1, glitch: 1'b1, en: 1'b1, exp_empty: 1'b1, exp_ferr: 1'b0};
        vecs[3] = '{d: 8'hA5, stop: 1'b1, glitch: 1'b0, en: 1'b1, exp_empty: 1'b0, exp_ferr: 1'b0};
        vecs[4] = '{d: 8'h5A, stop: 1'b1, glitch: 1'b0, en: 1'b0, exp_empty: 1'b1, exp_ferr: 1'b0};
        vecs[5] = '{d: 8'hFF, stop: 1'b1, glitch: 1'b0, en: 1'b1, exp_empty: 1'b0, exp_ferr: 1'b0};
        vecs[6] = '{d: 8'h01, stop: 1'b1, glitch: 1'b0, en: 1'b1, exp_empty: 1'b0, exp_ferr: 1'b0};
        vecs[7] = '{d: 8'h80, stop: 1'b1, glitch: 1'b0, en: 1'b1, exp_empty: 1'b0, exp_ferr: 1'b0};

        repeat (3) @(negedge clk);
        check("reset tx", {31'd0, tx}, 32'd1);
        check("reset tx_full", {31'd0, tx_full}, 32'd0);
        check("reset rx_empty", {31'd0, rx_empty}, 32'd1);
        check("reset read_rx_data", {24'd0, read_rx_data}, 32'd0);
        check("reset errors", {29'd0, frame_error, overrun_error, parity_error}, 32'd0);
        reset = 1'b1;
        repeat (5) @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            enable = vecs[i].en;
            if (vecs[i].glitch) begin
                rx_drv = 1'b0;
                repeat (8) @(negedge clk);
                rx_drv = 1'b1;
                repeat (200) @(negedge clk);
            end else begin
                send_frame(vecs[i].d, vecs[i].stop, 1'b0);
            end
            enable = 1'b1;
            check($sformatf("vec%0d rx_empty", i), {31'd0, rx_empty}, {31'd0, vecs[i].exp_empty});
            check($sformatf("vec%0d frame_error", i), {31'd0, frame_error}, {31'd0, vecs[i].exp_ferr});
            check($sformatf("vec%0d overrun_error", i), {31'd0, overrun_error}, 32'd0);
            if (!vecs[i].exp_empty) check($sformatf("vec%0d data", i), {24'd0, read_rx_data}, {24'd0, vecs[i].d});
            if (!rx_empty) pop();
            clear();
            check($sformatf("vec%0d frame_error cleared", i), {31'd0, frame_error}, 32'd0);
        end

        enable = 1'b1;
        push(8'h55);
        check_tx(8'h55, "tx55");

        loop = 1'b1;
        push(8'h00);
        push(8'hFF);
        push(8'hA5);
        repeat (600) @(negedge clk);
        check("loop data0", {24'd0, read_rx_data}, 32'h00);
        check("loop empty0", {31'd0, rx_empty}, 32'd0);
        pop();
        check("loop data1", {24'd0, read_rx_data}, 32'hFF);
        pop();
        check("loop data2", {24'd0, read_rx_data}, 32'hA5);
        pop();
        check("loop empty end", {31'd0, rx_empty}, 32'd1);
        check("loop errors", {29'd0, frame_error, overrun_error, parity_error}, 32'd0);
        loop = 1'b0;

        for (int i = 0; i < 17; i++) send_frame(8'(i * 13 + 5), 1'b1, 1'b0);
        check("overrun flag", {31'd0, overrun_error}, 32'd1);
        check("overrun frame_error", {31'd0, frame_error}, 32'd0);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("overrun data%0d", i), {24'd0, read_rx_data}, {24'd0, 8'(i * 13 + 5)});
            pop();
        end
        check("overrun drained", {31'd0, rx_empty}, 32'd1);
        clear();
        check("overrun cleared", {31'd0, overrun_error}, 32'd0);

`ifdef UART_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b1);
        check("parity error", {31'd0, parity_error}, 32'd1);
        check("parity dropped", {31'd0, rx_empty}, 32'd1);
        clear();
        check("parity cleared", {31'd0, parity_error}, 32'd0);
        send_frame(8'h07, 1'b1, 1'b0);
        check("parity good data", {24'd0, read_rx_data}, 32'h07);
        check("parity good flag", {31'd0, parity_error}, 32'd0);
        pop();
`else
        send_frame(8'h07, 1'b1, 1'b0);
        check("no parity data", {24'd0, read_rx_data}, 32'h07);
        check("no parity flag", {31'd0, parity_error}, 32'd0);
        pop();
`endif

        send_frame(8'h81, 1'b1, 1'b0);
        check("pre-reset rx word", {31'd0, rx_empty}, 32'd0);
        enable = 1'b0;
        for (int i = 0; i < 17; i++) push(8'(8'hC0 + i));
        check("tx_full", {31'd0, tx_full}, 32'd1);
        enable = 1'b1;
        wait_tx_start("reset frame", ok);
        push(8'hEE);
        repeat (16 * 4 + 8 - 2) @(negedge clk);
        check("tx bit3 before reset", {31'd0, tx}, 32'd0);
        check("tx_full before reset", {31'd0, tx_full}, 32'd1);
        reset = 1'b0;
        #1;
        check("async reset tx", {31'd0, tx}, 32'd1);
        check("async reset tx_full", {31'd0, tx_full}, 32'd0);
        check("async reset rx_empty", {31'd0, rx_empty}, 32'd1);
        check("async reset read_rx_data", {24'd0, read_rx_data}, 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (20) @(negedge clk);
        check("post-reset tx idle", {31'd0, tx}, 32'd1);
        push(8'h3C);
        check_tx(8'h3C, "post-reset tx3C");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
